pipe_stage_reg: RTL and testbench

Parametrised write-back stage register that supersedes the fixed MEM/WB latch. It carries the memory-data, ALU-result, destination-register and control payload from the MEM stage to the WB stage. It adds a valid/ready handshake with a two-entry skid buffer, a synchronous flush, overflow-qualified write enable, and a saturating back-pressure counter. It sits between the data-memory/ALU outputs and the register-file write port.

---
 rtl/pipe_stage_reg_if.sv | 71 +++++++
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
//
// Bundle of every non-clock, non-reset signal of the MEM/WB stage register.
//
//   Upstream (MEM side)
//     in_valid        payload valid from MEM
//     in_ready        stage can take a payload this cycle
//     in_mem_data     data-memory read value            [DATA_W]
//     in_alu_data     ALU result                        [DATA_W]
//     in_rw           destination register index        [RW_W]
//     in_reg_wr       register-write control
//     in_mem_to_reg   select memory data for write-back
//     in_overflow     ALU overflow flag
//     flush           discard held and incoming payloads
//
//   Downstream (WB side)
//     out_valid       held payload valid
//     out_ready       WB consumes the held payload
//     out_mem_data    held memory data                  [DATA_W]
//     out_alu_data    held ALU result                   [DATA_W]
//     out_rw          held destination index            [RW_W]
//     out_mem_to_reg  held select
//     out_overflow    held overflow flag
//     out_reg_wr      qualified register-file write enable
//     out_wb_data     selected write-back value         [DATA_W]
//     stall_cnt       saturating back-pressure counter  [CNT_W]
//
// Modports: slave is the stage register itself, master is whatever drives
// the MEM side and consumes the WB side (pipeline neighbours or a bench).
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int RW_W   = 5,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mem_data;
    logic [DATA_W-1:0] in_alu_data;
    logic [RW_W-1:0]   in_rw;
    logic              in_reg_wr;
    logic              in_mem_to_reg;
    logic              in_overflow;
    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_mem_data;
    logic [DATA_W-1:0] out_alu_data;
    logic [RW_W-1:0]   out_rw;
    logic              out_mem_to_reg;
    logic              out_overflow;
    logic              out_reg_wr;
    logic [DATA_W-1:0] out_wb_data;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  in_valid, in_mem_data, in_alu_data, in_rw,
               in_reg_wr, in_mem_to_reg, in_overflow, flush, out_ready,
        output in_ready, out_valid, out_mem_data, out_alu_data, out_rw,
               out_mem_to_reg, out_overflow, out_reg_wr, out_wb_data, stall_cnt
    );

    modport master (
        output in_valid, in_mem_data, in_alu_data, in_rw,
               in_reg_wr, in_mem_to_reg, in_overflow, flush, out_ready,
        input  in_ready, out_valid, out_mem_data, out_alu_data, out_rw,
               out_mem_to_reg, out_overflow, out_reg_wr, out_wb_data, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// MEM/WB stage register with a valid/ready handshake and a two-entry skid
// buffer. Entry M drives the outputs; entry S absorbs the one payload that
// may arrive in the cycle WB stops consuming. in_ready depends only on
// registered state, so there is no combinational path from out_ready back to
// the MEM stage.
//
// All state updates happen on the falling clock edge to line up with the
// other pipeline registers. Reset is synchronous, active-low, sampled on that
// same falling edge.
//
// Ports
//   clk    clock (state changes on negedge)
//   rst_n  synchronous active-low reset
//   bus    pipe_stage_reg_if.slave, see the interface for the signal list
//
// Parameters must match those of the connected interface instance.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int RW_W   = 5,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            rst_n,
    pipe_stage_reg_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_data;
        logic [RW_W-1:0]   rw;
        logic              reg_wr;
        logic              mem_to_reg;
        logic              overflow;
    } payload_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    payload_t         m_q;
    payload_t         s_q;
    logic             m_valid_q;
    logic             s_valid_q;
    logic [CNT_W-1:0] stall_cnt_q;

    payload_t         in_payload;
    logic             accept;
    logic             consume;

    // NOTE: every signal driven from always_comb gets a default first so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        in_payload            = '0;
        in_payload.mem_data   = bus.in_mem_data;
        in_payload.alu_data   = bus.in_alu_data;
        in_payload.rw         = bus.in_rw;
        in_payload.reg_wr     = bus.in_reg_wr;
        in_payload.mem_to_reg = bus.in_mem_to_reg;
        in_payload.overflow   = bus.in_overflow;
    end

    // The skid entry being full is the only reason to refuse input; M alone
    // full is fine because S can still take one payload.
    assign bus.in_ready = ~s_valid_q;
    assign accept       = bus.in_valid & ~s_valid_q;
    assign consume      = m_valid_q & bus.out_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the value from before this edge.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            // NOTE: payload fields are reset too (not just valid bits) so the
            // outputs read all-zero after reset; flush clears valid bits only.
            m_q         <= '0;
            s_q         <= '0;
            m_valid_q   <= 1'b0;
            s_valid_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            // Back-pressure statistic runs independently of flush.
            if (m_valid_q && !bus.out_ready && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end

            if (bus.flush) begin
                // Anything accepted this edge is dropped along with M and S.
                m_valid_q <= 1'b0;
                s_valid_q <= 1'b0;
            end else if (!m_valid_q) begin
                // S is never valid while M is empty, so input goes to M.
                if (accept) begin
                    m_q       <= in_payload;
                    m_valid_q <= 1'b1;
                end
            end else if (consume) begin
                if (s_valid_q) begin
                    // in_ready was low, so nothing new arrives this edge.
                    m_q       <= s_q;
                    s_valid_q <= 1'b0;
                end else if (accept) begin
                    m_q <= in_payload;
                end else begin
                    m_valid_q <= 1'b0;
                end
            end else if (accept) begin
                // WB stalled: park the in-flight payload behind M.
                s_q       <= in_payload;
                s_valid_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid      = m_valid_q;
    assign bus.out_mem_data   = m_q.mem_data;
    assign bus.out_alu_data   = m_q.alu_data;
    assign bus.out_rw         = m_q.rw;
    assign bus.out_mem_to_reg = m_q.mem_to_reg;
    assign bus.out_overflow   = m_q.overflow;
    assign bus.stall_cnt      = stall_cnt_q;

    // Writes to r0 are discarded and an overflowing result never reaches the
    // register file; the raw flag still goes out for exception handling.
    assign bus.out_reg_wr  = m_valid_q & m_q.reg_wr & ~m_q.overflow & (m_q.rw != '0);
    assign bus.out_wb_data = m_q.mem_to_reg ? m_q.mem_data : m_q.alu_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. dut drives the default widths; dut_s
// uses CNT_W=4 to exercise stall counter saturation. Inputs change and
// outputs are checked 1 time unit after each falling (active) edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int RW_W   = 5;

    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .RW_W(RW_W), .CNT_W(16)) ifc ();
    pipe_stage_reg_if #(.DATA_W(DATA_W), .RW_W(RW_W), .CNT_W(4))  ifc_s ();

    pipe_stage_reg #(.DATA_W(DATA_W), .RW_W(RW_W), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .RW_W(RW_W), .CNT_W(4)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] rw, input logic reg_wr, input logic m2r,
                         input logic ovf);
        ifc.in_valid      = valid;
        ifc.in_mem_data   = mem;
        ifc.in_alu_data   = alu;
        ifc.in_rw         = rw;
        ifc.in_reg_wr     = reg_wr;
        ifc.in_mem_to_reg = m2r;
        ifc.in_overflow   = ovf;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        rst_n          = 1'b0;
        ifc.flush      = 1'b0;
        ifc.out_ready  = 1'b0;
        drive(1'b1, 32'h1111_1111, 32'h2222_2222, 5'd9, 1'b1, 1'b1, 1'b0);
        ifc_s.in_valid      = 1'b0;
        ifc_s.in_mem_data   = '0;
        ifc_s.in_alu_data   = '0;
        ifc_s.in_rw         = '0;
        ifc_s.in_reg_wr     = 1'b0;
        ifc_s.in_mem_to_reg = 1'b0;
        ifc_s.in_overflow   = 1'b0;
        ifc_s.flush         = 1'b0;
        ifc_s.out_ready     = 1'b0;

        // ---- reset: two edges low with a valid payload presented ----------
        tick();
        tick();
        check("rst out_valid",    ifc.out_valid, 0);
        check("rst in_ready",     ifc.in_ready, 1);
        check("rst stall_cnt",    ifc.stall_cnt, 0);
        check("rst out_reg_wr",   ifc.out_reg_wr, 0);
        check("rst out_wb_data",  ifc.out_wb_data, 0);
        check("rst out_alu_data", ifc.out_alu_data, 0);
        check("rst out_mem_data", ifc.out_mem_data, 0);
        check("rst out_rw",       ifc.out_rw, 0);
        check("rst_s stall_cnt",  ifc_s.stall_cnt, 0);
        rst_n = 1'b1;

        // ---- streaming: 8 payloads, one per cycle, latency one edge --------
        ifc.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'h0, i, i[4:0], 1'b1, 1'b0, 1'b0);
            tick();
            check($sformatf("stream%0d valid", i),  ifc.out_valid, 1);
            check($sformatf("stream%0d alu", i),    ifc.out_alu_data, i);
            check($sformatf("stream%0d reg_wr", i), ifc.out_reg_wr, 1);
            check($sformatf("stream%0d ready", i),  ifc.in_ready, 1);
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("stream drain valid", ifc.out_valid, 0);
        check("stream stall_cnt",   ifc.stall_cnt, 0);

        // ---- back-pressure: 1 into M, 2 into S, 3 held upstream -----------
        ifc.out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0, 32'd2, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        check("bp in_ready after S fill", ifc.in_ready, 0);
        drive(1'b1, 32'h0, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check("bp M holds 1",   ifc.out_alu_data, 1);
        check("bp out_valid",   ifc.out_valid, 1);
        check("bp in_ready",    ifc.in_ready, 0);
        check("bp stall_cnt",   ifc.stall_cnt, 3);
        ifc.out_ready = 1'b1;
        tick();
        check("bp out 2",       ifc.out_alu_data, 2);
        check("bp in_ready up", ifc.in_ready, 1);
        tick();
        check("bp out 3",       ifc.out_alu_data, 3);
        check("bp out 3 valid", ifc.out_valid, 1);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bp no duplicate", ifc.out_valid, 0);
        check("bp stall kept",   ifc.stall_cnt, 3);

        // ---- qualification -------------------------------------------------
        drive(1'b1, 32'h0, 32'h55, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check("q rw0 valid",  ifc.out_valid, 1);
        check("q rw0 reg_wr", ifc.out_reg_wr, 0);
        drive(1'b1, 32'h0, 32'h66, 5'd7, 1'b1, 1'b0, 1'b1);
        tick();
        check("q ovf reg_wr", ifc.out_reg_wr, 0);
        check("q ovf flag",   ifc.out_overflow, 1);
        check("q ovf rw",     ifc.out_rw, 7);
        check("q ovf alu",    ifc.out_alu_data, 32'h66);
        drive(1'b1, 32'hDEAD_BEEF, 32'h1, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        check("q m2r wb_data", ifc.out_wb_data, 32'hDEAD_BEEF);
        check("q m2r reg_wr",  ifc.out_reg_wr, 1);
        drive(1'b1, 32'hDEAD_BEEF, 32'h1, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        check("q alu wb_data", ifc.out_wb_data, 32'h1);
        check("q no reg_wr",   ifc.out_reg_wr, 0);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("q drain valid", ifc.out_valid, 0);

        // ---- flush with both entries full and input valid ------------------
        ifc.out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'd10, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0, 32'd11, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        check("fl S full", ifc.in_ready, 0);
        drive(1'b1, 32'h0, 32'd12, 5'd6, 1'b1, 1'b0, 1'b0);
        ifc.flush = 1'b1;
        tick();
        check("fl out_valid", ifc.out_valid, 0);
        check("fl in_ready",  ifc.in_ready, 1);
        check("fl reg_wr",    ifc.out_reg_wr, 0);
        check("fl stall_cnt", ifc.stall_cnt, 5);
        ifc.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("fl payload absent", ifc.out_valid, 0);
        // flush also drops a payload accepted into an empty stage
        drive(1'b1, 32'h0, 32'd13, 5'd6, 1'b1, 1'b0, 1'b0);
        ifc.flush = 1'b1;
        tick();
        check("fl drop accept", ifc.out_valid, 0);
        ifc.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        // ---- saturation on the CNT_W=4 instance ---------------------------
        ifc_s.in_valid    = 1'b1;
        ifc_s.in_alu_data = 32'h77;
        ifc_s.in_rw       = 5'd2;
        ifc_s.in_reg_wr   = 1'b1;
        tick();
        ifc_s.in_valid = 1'b0;
        check("sat loaded", ifc_s.out_valid, 1);
        check("sat start",  ifc_s.stall_cnt, 0);
        tick();
        check("sat one", ifc_s.stall_cnt, 1);
        for (int i = 0; i < 13; i++) tick();
        check("sat fourteen", ifc_s.stall_cnt, 14);
        for (int i = 0; i < 6; i++) tick();
        check("sat hold 15", ifc_s.stall_cnt, 15);
        check("sat M held",  ifc_s.out_alu_data, 32'h77);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
